// File: rtl/clk_period_detector.sv
// Measures the full period of sig_in in clk cycles, classifies it against the
// divider's four nominal beat periods and tracks lock / signal-loss status.
module clk_period_detector #(
  parameter int unsigned clk_freq = 12_000_000,
  parameter int unsigned TOL      = 64,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [3:0]  period_code,
  output logic [31:0] meas_cycles,
  output logic        meas_valid,
  output logic        locked,
  output logic        sig_lost
);

  localparam logic [31:0] N1      = 32'(2 * (clk_freq / 600 / 2 + 1));
  localparam logic [31:0] N2      = 32'(2 * (clk_freq / 300 / 2 + 1));
  localparam logic [31:0] N3      = 32'(2 * (clk_freq / 200 / 2 + 1));
  localparam logic [31:0] N4      = 32'(2 * (clk_freq / 150 / 2 + 1));
  localparam logic [31:0] TIMEOUT = 2 * N4;
  localparam int unsigned SW      = $clog2(LOCK_CNT + 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t        state;
  logic          sync1, sync2, prev;
  logic          rise;
  logic [31:0]   counter;
  logic [SW-1:0] streak;
  logic [3:0]    code_new;
  logic [SW-1:0] streak_new;

  function automatic logic near(input logic [31:0] c, input logic [31:0] n);
    logic [31:0] d;
    d = (c >= n) ? (c - n) : (n - c);
    return d <= TOL;
  endfunction

  assign rise = sync2 & ~prev;

  // Checked from highest to lowest code so the lowest matching code wins.
  always_comb begin
    code_new = '0;
    if (near(counter, N4)) code_new = 4'd4;
    if (near(counter, N3)) code_new = 4'd3;
    if (near(counter, N2)) code_new = 4'd2;
    if (near(counter, N1)) code_new = 4'd1;
    if (code_new != '0 && code_new == period_code)
      streak_new = (streak == SW'(LOCK_CNT)) ? streak : streak + 1'b1;
    else
      streak_new = (code_new != '0) ? SW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      prev        <= 1'b0;
      state       <= IDLE;
      counter     <= '0;
      streak      <= '0;
      period_code <= '0;
      meas_cycles <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      sig_lost    <= 1'b0;
    end else begin
      sync1      <= sig_in;
      sync2      <= sync1;
      prev       <= sync2;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (rise) begin
            counter  <= 32'd1;
            sig_lost <= 1'b0;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          // A rise coinciding with the timeout still counts as a measurement.
          if (rise) begin
            meas_cycles <= counter;
            period_code <= code_new;
            meas_valid  <= 1'b1;
            streak      <= streak_new;
            locked      <= (streak_new == SW'(LOCK_CNT));
            counter     <= 32'd1;
          end else if (counter == TIMEOUT) begin
            sig_lost    <= 1'b1;
            period_code <= '0;
            locked      <= 1'b0;
            streak      <= '0;
            counter     <= '0;
            state       <= IDLE;
          end else begin
            counter <= counter + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
